// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter: shares the single-port sprite image memory between the
// HPS pixel loader (buffered writes) and vga_display (reads, with priority).
// A starvation guard forces one queued write past a continuous read stream
// after STARVE_LIMIT waiting cycles.
// Optional build macro ARB_STATS_EN adds the rd_stall_cnt / wr_full_cnt
// saturating statistics outputs.
module sprite_mem_arbiter #(
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned DATA_W       = 24,
    parameter int unsigned WQ_DEPTH     = 8,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_req,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_gnt,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_we,
    output logic [DATA_W-1:0]          mem_din,
    input  logic [DATA_W-1:0]          mem_dout,
    output logic [$clog2(WQ_DEPTH):0]  wq_count
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]                rd_stall_cnt,
    output logic [15:0]                wr_full_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(WQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_RD   = 2'd1;
    localparam logic [1:0] GNT_WR   = 2'd2;

    logic [ADDR_W-1:0] wq_addr [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data [WQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [STV_W-1:0]  starve_cnt;
    logic [1:0]        gnt_q;
    logic [1:0]        gnt_c;
    logic              force_wr_c;
    logic              push_c;
    logic              pop_c;

    assign wr_ready = (wq_count < CNT_W'(WQ_DEPTH));
    assign push_c   = wr_valid & wr_ready & ~clear;
    assign pop_c    = (gnt_c == GNT_WR);
    assign rd_gnt   = (gnt_c == GNT_RD);
    // Memory output is only meaningful in the cycle rd_valid flags it.
    assign rd_data  = rd_valid ? mem_dout : '0;

    // Grant state register: remembers last cycle's grant to pace the read pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q <= GNT_NONE;
        end else begin
            gnt_q <= gnt_c;
        end
    end

    // Arbitration on current inputs: reads first unless a write has starved.
    always_comb begin
        gnt_c      = GNT_NONE;
        force_wr_c = (wq_count != '0) && (starve_cnt >= STV_W'(STARVE_LIMIT));
        if (reset) begin
            gnt_c = GNT_NONE;
        end else if (rd_req && !force_wr_c) begin
            gnt_c = GNT_RD;
        end else if (wq_count != '0) begin
            gnt_c = GNT_WR;
        end
    end

    // Write queue storage; no reset needed, occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push_c) begin
            wq_addr[wr_ptr] <= wr_addr;
            wq_data[wr_ptr] <= wr_data;
        end
    end

    // Write queue pointers and occupancy; clear discards everything queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wq_count <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wq_count <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   wq_count <= wq_count + CNT_W'(1);
                2'b01:   wq_count <= wq_count - CNT_W'(1);
                default: wq_count <= wq_count;
            endcase
        end
    end

    // Starvation counter: cycles a queued write has waited behind reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (clear || (wq_count == '0) || pop_c) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STV_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    // Memory port registers driven from this cycle's grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_we   <= 1'b0;
            mem_din  <= '0;
        end else begin
            case (gnt_c)
                GNT_RD: begin
                    mem_addr <= rd_addr;
                    mem_we   <= 1'b0;
                end
                GNT_WR: begin
                    mem_addr <= wq_addr[rd_ptr];
                    mem_din  <= wq_data[rd_ptr];
                    mem_we   <= 1'b1;
                end
                default: begin
                    mem_we   <= 1'b0;
                end
            endcase
        end
    end

    // Read data valid two cycles after the grant (address reg + sync memory).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= (gnt_q == GNT_RD);
        end
    end

`ifdef ARB_STATS_EN
    // Saturating stall statistics for the reader and the loader.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_stall_cnt <= '0;
            wr_full_cnt  <= '0;
        end else if (clear) begin
            rd_stall_cnt <= '0;
            wr_full_cnt  <= '0;
        end else begin
            if (rd_req && !rd_gnt && (rd_stall_cnt != 16'hFFFF)) begin
                rd_stall_cnt <= rd_stall_cnt + 16'd1;
            end
            if (wr_valid && !wr_ready && (wr_full_cnt != 16'hFFFF)) begin
                wr_full_cnt <= wr_full_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed self-checking bench for sprite_mem_arbiter with a 1-cycle
// synchronous-read memory model on the memory port.
module tb_sprite_mem_arbiter;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 24;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic [3:0]        wq_count;
`ifdef ARB_STATS_EN
    logic [15:0]       rd_stall_cnt;
    logic [15:0]       wr_full_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem_model [0:4095];

    sprite_mem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .wq_count (wq_count)
`ifdef ARB_STATS_EN
        ,
        .rd_stall_cnt (rd_stall_cnt),
        .wr_full_cnt  (wr_full_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Single-port memory, read-first, one cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr[11:0]] <= mem_din;
        mem_dout <= mem_model[mem_addr[11:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rd_req   = 1'b1;
        wr_valid = 1'b1;
        #2;
        checks++; if (rd_gnt !== 1'b0) begin errors++; $display("FAIL reset_rd_gnt: got %b expected 0", rd_gnt); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        checks++; if (wq_count !== 4'd0) begin errors++; $display("FAIL reset_wq_count: got %0d expected 0", wq_count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== 24'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 000000", rd_data); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 20'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00000", mem_addr); end
        checks++; if (mem_din !== 24'h0) begin errors++; $display("FAIL reset_mem_din: got %h expected 000000", mem_din); end
        tick;
        checks++; if (wq_count !== 4'd0) begin errors++; $display("FAIL reset_push_ignored: got %0d expected 0", wq_count); end
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        reset    = 1'b0;
        tick;
    endtask

    task automatic test_writes;
        wr_valid = 1'b1; wr_addr = 20'h00001; wr_data = 24'h112233;
        tick;
        checks++; if (wq_count !== 4'd1) begin errors++; $display("FAIL wr_count_n1: got %0d expected 1", wq_count); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_n1: got %b expected 0", mem_we); end
        wr_addr = 20'h00002; wr_data = 24'h445566;
        tick;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 20'h00001 || mem_din !== 24'h112233) begin
            errors++; $display("FAIL wr_first: got we=%b addr=%h din=%h expected we=1 addr=00001 din=112233", mem_we, mem_addr, mem_din); end
        checks++; if (wq_count !== 4'd1) begin errors++; $display("FAIL wr_push_pop_count: got %0d expected 1", wq_count); end
        wr_addr = 20'h00003; wr_data = 24'h778899;
        tick;
        wr_valid = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 20'h00002 || mem_din !== 24'h445566) begin
            errors++; $display("FAIL wr_second: got we=%b addr=%h din=%h expected we=1 addr=00002 din=445566", mem_we, mem_addr, mem_din); end
        tick;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 20'h00003 || mem_din !== 24'h778899) begin
            errors++; $display("FAIL wr_third: got we=%b addr=%h din=%h expected we=1 addr=00003 din=778899", mem_we, mem_addr, mem_din); end
        checks++; if (wq_count !== 4'd0) begin errors++; $display("FAIL wr_drained: got %0d expected 0", wq_count); end
        tick;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_idle: got %b expected 0", mem_we); end
    endtask

    task automatic test_read;
        wr_valid = 1'b1; wr_addr = 20'h00010; wr_data = 24'hABCDEF;
        tick;
        wr_valid = 1'b0;
        repeat (3) tick;
        rd_req = 1'b1; rd_addr = 20'h00010;
        #1;
        checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b expected 1", rd_gnt); end
        tick;
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_n1: got %b expected 0", rd_valid); end
        checks++; if (mem_addr !== 20'h00010 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rd_mem_port: got addr=%h we=%b expected addr=00010 we=0", mem_addr, mem_we); end
        tick;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 24'hABCDEF) begin
            errors++; $display("FAIL rd_data_n2: got valid=%b data=%h expected valid=1 data=abcdef", rd_valid, rd_data); end
        tick;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_n3: got %b expected 0", rd_valid); end
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] exp_d [3];
        exp_d[0] = 24'h112233; exp_d[1] = 24'h445566; exp_d[2] = 24'h778899;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                rd_req = 1'b1; rd_addr = 20'(i + 1);
            end else begin
                rd_req = 1'b0;
            end
            #1;
            if (i < 3) begin
                checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected 1", i, rd_gnt); end
            end
            if (i >= 2) begin
                checks++; if (rd_valid !== 1'b1 || rd_data !== exp_d[i-2]) begin
                    errors++; $display("FAIL b2b_data[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, rd_valid, rd_data, exp_d[i-2]); end
            end
            tick;
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", rd_valid); end
    endtask

    task automatic test_starvation;
        int pushed;
        logic exp_gnt, exp_ready, exp_we;
        logic [3:0] exp_cnt;
        clear = 1'b1;
        tick;
        clear = 1'b0;
`ifdef ARB_STATS_EN
        checks++; if (rd_stall_cnt !== 16'd0 || wr_full_cnt !== 16'd0) begin
            errors++; $display("FAIL stats_pre: got stall=%0d full=%0d expected 0 0", rd_stall_cnt, wr_full_cnt); end
`endif
        pushed = 0;
        for (int c = 0; c < 36; c++) begin
            rd_req   = 1'b1;
            rd_addr  = 20'h00010;
            wr_valid = (pushed < 9);
            wr_addr  = 20'h00100 + 20'(pushed);
            wr_data  = 24'h0A0000 + 24'(pushed);
            #1;
            exp_gnt   = !(c == 17 || c == 34);
            exp_ready = !((c >= 8 && c <= 17) || (c >= 19 && c <= 34));
            exp_we    = (c == 18 || c == 35);
            if (c < 8)        exp_cnt = 4'(c);
            else if (c <= 17) exp_cnt = 4'd8;
            else if (c == 18) exp_cnt = 4'd7;
            else if (c <= 34) exp_cnt = 4'd8;
            else              exp_cnt = 4'd7;
            checks++; if (rd_gnt !== exp_gnt) begin errors++; $display("FAIL starve_gnt c=%0d: got %b expected %b", c, rd_gnt, exp_gnt); end
            checks++; if (wr_ready !== exp_ready) begin errors++; $display("FAIL starve_ready c=%0d: got %b expected %b", c, wr_ready, exp_ready); end
            checks++; if (wq_count !== exp_cnt) begin errors++; $display("FAIL starve_count c=%0d: got %0d expected %0d", c, wq_count, exp_cnt); end
            checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL starve_we c=%0d: got %b expected %b", c, mem_we, exp_we); end
            if (c == 18) begin
                checks++; if (mem_addr !== 20'h00100 || mem_din !== 24'h0A0000) begin
                    errors++; $display("FAIL starve_write1: got addr=%h din=%h expected 00100 0a0000", mem_addr, mem_din); end
            end
            if (c == 35) begin
                checks++; if (mem_addr !== 20'h00101 || mem_din !== 24'h0A0001) begin
                    errors++; $display("FAIL starve_write2: got addr=%h din=%h expected 00101 0a0001", mem_addr, mem_din); end
            end
            if (wr_valid && wr_ready) pushed++;
            tick;
        end
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        checks++; if (pushed != 9) begin errors++; $display("FAIL starve_ninth_push: got %0d pushes expected 9", pushed); end
`ifdef ARB_STATS_EN
        checks++; if (rd_stall_cnt !== 16'd2) begin errors++; $display("FAIL stats_stall: got %0d expected 2", rd_stall_cnt); end
        checks++; if (wr_full_cnt !== 16'd10) begin errors++; $display("FAIL stats_full: got %0d expected 10", wr_full_cnt); end
`endif
        repeat (10) tick;
        checks++; if (wq_count !== 4'd0) begin errors++; $display("FAIL starve_drain: got %0d expected 0", wq_count); end
    endtask

    task automatic test_clear;
        for (int c = 0; c < 5; c++) begin
            rd_req = 1'b1; rd_addr = 20'h00010;
            wr_valid = 1'b1; wr_addr = 20'h00300 + 20'(c); wr_data = 24'h0C0000 + 24'(c);
            tick;
        end
        wr_addr = 20'h002FF; wr_data = 24'hDEAD00;
        clear = 1'b1;
        #1;
        checks++; if (wq_count !== 4'd5) begin errors++; $display("FAIL clear_pre_count: got %0d expected 5", wq_count); end
        tick;
        clear = 1'b0;
        wr_valid = 1'b0;
        checks++; if (wq_count !== 4'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", wq_count); end
`ifdef ARB_STATS_EN
        checks++; if (rd_stall_cnt !== 16'd0 || wr_full_cnt !== 16'd0) begin
            errors++; $display("FAIL stats_clear: got stall=%0d full=%0d expected 0 0", rd_stall_cnt, wr_full_cnt); end
`endif
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++; if (mem_we !== 1'b0 || rd_gnt !== 1'b1) begin
                errors++; $display("FAIL clear_no_write c=%0d: got we=%b gnt=%b expected we=0 gnt=1", c, mem_we, rd_gnt); end
            tick;
        end
        rd_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (mem_we !== 1'b0 || wq_count !== 4'd0) begin
                errors++; $display("FAIL clear_idle c=%0d: got we=%b count=%0d expected we=0 count=0", c, mem_we, wq_count); end
            tick;
        end
    endtask

    task automatic test_reset_mid;
        rd_req = 1'b1; rd_addr = 20'h00001;
        wr_valid = 1'b1; wr_addr = 20'h00400; wr_data = 24'h0D0000;
        tick;
        tick;
        reset = 1'b1;
        #1;
        checks++; if (wq_count !== 4'd0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_fifo: got count=%0d ready=%b expected 0 1", wq_count, wr_ready); end
        checks++; if (rd_gnt !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 24'h0) begin
            errors++; $display("FAIL midreset_read: got gnt=%b valid=%b data=%h expected 0 0 000000", rd_gnt, rd_valid, rd_data); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 20'h0 || mem_din !== 24'h0) begin
            errors++; $display("FAIL midreset_mem: got we=%b addr=%h din=%h expected 0 00000 000000", mem_we, mem_addr, mem_din); end
        tick;
        rd_req = 1'b0;
        wr_valid = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++; if (rd_valid !== 1'b0 || mem_we !== 1'b0 || wq_count !== 4'd0) begin
                errors++; $display("FAIL postreset c=%0d: got valid=%b we=%b count=%0d expected 0 0 0", c, rd_valid, mem_we, wq_count); end
        end
    endtask

    initial begin
        test_reset;
        test_writes;
        test_read;
        test_back_to_back;
        test_starvation;
        test_clear;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
